// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide engine owning the architectural HI/LO registers.
// One product/quotient bit per cycle, fixed latency, sign fix-up in a final state.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   srca,
    input  logic [WIDTH-1:0]   srcb,
    input  logic               abort,
    input  logic               wrhi,
    input  logic               wrlo,
    input  logic               rdhilo,
    output logic               busy,
    output logic               done,
    output logic               stall,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic [1:0]         o_dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_DIV   = 2'd2,
        S_FIXUP = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_load;
    logic                 w_write;

    logic [CW-1:0]        r_count;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opnd;
    logic [WIDTH-1:0]     r_raw_a;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_divz;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;

    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_acc;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH+1:0]     w_diff;
    logic                 w_div_neg;
    logic [2*WIDTH-1:0]   w_div_acc;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;

    // Only the signed ops (op[0]=1) take magnitudes; unsigned operands pass through.
    assign w_a_neg = op[0] & srca[WIDTH-1];
    assign w_b_neg = op[0] & srcb[WIDTH-1];
    assign w_abs_a = w_a_neg ? -srca : srca;
    assign w_abs_b = w_b_neg ? -srcb : srcb;

    // Multiply: acc = {partial, multiplier}; add on LSB, then shift right.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
    assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff    = {1'b0, w_rem_sh} - {2'b00, r_opnd};
    assign w_div_neg = w_diff[WIDTH+1];
    assign w_div_acc = {(w_div_neg ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], ~w_div_neg};

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quot = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            if (r_divz) begin
                w_res_hi = r_raw_a;
                w_res_lo = '1;
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quot;
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_write = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_load = 1'b1;
                    w_next = op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (r_count == LAST) begin
                    w_next = S_FIXUP;
                end
            end
            S_FIXUP: begin
                w_next  = S_IDLE;
                w_write = !abort;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_raw_a  <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_divz   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_write;
            if (w_load) begin
                r_count  <= '0;
                r_is_div <= op[1];
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
                r_divz   <= (srcb == '0);
                r_raw_a  <= srca;
                r_opnd   <= op[1] ? w_abs_b : w_abs_a;
                r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
            end else if (r_state == S_MUL || r_state == S_DIV) begin
                r_count <= r_count + 1'b1;
                r_acc   <= (r_state == S_MUL) ? w_mul_acc : w_div_acc;
            end
            // Result write and mthi/mtlo are mutually exclusive: writes only land in IDLE.
            if (w_write) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (r_state == S_IDLE) begin
                if (wrhi) r_hi <= srca;
                if (wrlo) r_lo <= srca;
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign stall       = busy & (rdhilo | start | wrhi | wrlo);
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed and random ops scored
// against an arithmetic model, plus stall, abort and async-reset scenarios.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] srca;
  logic [W-1:0] srcb;
  logic         abort;
  logic         wrhi;
  logic         wrlo;
  logic         rdhilo;
  logic         busy;
  logic         done;
  logic         stall;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [1:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*W-1:0] exp_q[$];

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .abort(abort), .wrhi(wrhi), .wrlo(wrlo), .rdhilo(rdhilo),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (o)
      2'd0: res = {32'b0, a} * {32'b0, b};
      2'd1: res = sa * sb;
      2'd2: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else        res = {a % b, a / b};
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // driver tasks: all called at #1 after a rising edge
  task automatic idle_inputs();
    start = 0; op = 0; srca = 0; srcb = 0; abort = 0; wrhi = 0; wrlo = 0; rdhilo = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back(model(o, a, b));
    start = 1; op = o; srca = a; srcb = b;
    step();
    start = 0; srca = $urandom; srcb = $urandom;
  endtask

  // Called right after issue(): counts edges to done, scores the popped result.
  task automatic wait_done(input string tag);
    int n = 0;
    int busy_cycles = 0;
    logic [63:0] e;
    if (busy) busy_cycles++;
    while (n < 100) begin
      step();
      n++;
      if (done) break;
      if (busy) busy_cycles++;
    end
    if (!done) begin
      check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check_eq({tag, "_latency"}, 64'(n), 64'd33);
      check_eq({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd33);
      check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      if (exp_q.size() == 0) begin
        check_eq({tag, "_queue_empty"}, 64'd0, 64'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq({tag, "_hilo"}, {hi, lo}, e);
      end
      step();
      check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
    end
  endtask

  typedef struct packed { logic [1:0] o; logic [31:0] a; logic [31:0] b; } vec_t;

  initial begin
    vec_t vecs[8];
    int cnt;
    logic [31:0] ra, rb;
    logic [1:0]  ro;

    idle_inputs();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    rdhilo = 1;
    #1;
    check_eq("rst_hi", hi, 0);
    check_eq("rst_lo", lo, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_stall_idle", stall, 0);
    rdhilo = 0;
    reset = 1;
    step();

    vecs[0] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[1] = '{2'd1, 32'hFFFF_FFF9, 32'd3};
    vecs[2] = '{2'd3, 32'hFFFF_FFF9, 32'd2};
    vecs[3] = '{2'd2, 32'd100, 32'd7};
    vecs[4] = '{2'd2, 32'h0000_1234, 32'd0};
    vecs[5] = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF};
    vecs[6] = '{2'd3, 32'hFFFF_FF00, 32'd0};
    vecs[7] = '{2'd1, 32'h8000_0000, 32'h8000_0000};
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].o, vecs[i].a, vecs[i].b);
      wait_done($sformatf("dir%0d", i));
    end

    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 0;
        1: rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) ra = ra >> $urandom_range(0, 31);
      issue(ro, ra, rb);
      wait_done($sformatf("rnd%0d", i));
    end

    // start together with mtlo: the write lands and the op uses srca
    wrlo = 1;
    exp_q.push_back(model(2'd0, 32'd6, 32'd7));
    start = 1; op = 2'd0; srca = 32'd6; srcb = 32'd7;
    step();
    start = 0; wrlo = 0;
    check_eq("wrlo_with_start_lo", lo, 32'd6);
    check_eq("wrlo_with_start_busy", busy, 1);
    wait_done("wrlo_start");

    // start with abort in IDLE is dropped, mthi still applies
    start = 1; abort = 1; wrhi = 1; op = 2'd0; srca = 32'h1111_2222; srcb = 32'd5;
    step();
    idle_inputs();
    check_eq("idle_abort_busy", busy, 0);
    check_eq("idle_abort_hi", hi, 32'h1111_2222);

    // stall while reading hi/lo during an op; mthi held until stall drops
    issue(2'd0, 32'd3, 32'd5);
    rdhilo = 1; wrhi = 1; srca = 32'hDEAD_BEEF;
    #1;
    cnt = 0;
    for (int n = 0; n < 100; n++) begin
      if (done) break;
      if (stall) cnt++;
      @(posedge clk);
      #2;
    end
    check_eq("stall_cycles", 64'(cnt), 64'd33);
    check_eq("stall_done_seen", 64'(done), 64'd1);
    check_eq("stall_low_idle", 64'(stall), 64'd0);
    if (exp_q.size() != 0) check_eq("stall_hilo", {hi, lo}, exp_q.pop_front());
    step();
    check_eq("wrhi_after_done_hi", hi, 32'hDEAD_BEEF);
    check_eq("wrhi_after_done_lo", lo, 32'd15);
    idle_inputs();

    // preload then abort a divide mid-flight
    wrhi = 1; wrlo = 1; srca = 32'hA5A5_A5A5;
    step();
    idle_inputs();
    check_eq("preload_hilo", {hi, lo}, {32'hA5A5_A5A5, 32'hA5A5_A5A5});
    start = 1; op = 2'd2; srca = 32'd100; srcb = 32'd7;
    step();
    start = 0;
    repeat (9) step();
    abort = 1;
    step();
    abort = 0;
    check_eq("abort_busy", busy, 0);
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (done) cnt++;
    end
    check_eq("abort_no_done", 64'(cnt), 64'd0);
    check_eq("abort_hilo", {hi, lo}, {32'hA5A5_A5A5, 32'hA5A5_A5A5});

    // async reset in the middle of a multiply
    start = 1; op = 2'd1; srca = 32'hFFFF_FFF9; srcb = 32'd3;
    step();
    start = 0;
    repeat (5) step();
    #2;
    reset = 0;
    #1;
    check_eq("async_rst_hi", hi, 0);
    check_eq("async_rst_lo", lo, 0);
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_done", done, 0);
    step();
    reset = 1;
    step();
    issue(2'd1, 32'hFFFF_FFF9, 32'd3);
    wait_done("post_reset");

    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
